mc_ctrl_fsm: RTL and testbench

//  Multi-cycle main controller sequencing the shared regfile/ALU/data-memory datapath.

---
 rtl/mc_ctrl_pkg.sv | 29 ++
 rtl/mc_ctrl_fsm_if.sv | 31 +++
 rtl/mc_ctrl_fsm_alu_decoder.sv | 25 ++
 rtl/mc_ctrl_fsm.sv | 149 ++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I main controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR,
    MEMRD, MEMWB, MEMWR, BRANCH, JAL, TRAP
  } state_t;

  // RV32I major opcodes the controller understands
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation encoding
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Writeback result mux encoding
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mc_ctrl_fsm_if #(
  parameter int CONTROL_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
);
  logic [DATA_WIDTH-1:0]    Instr_i;
  logic                     Zero_i;
  logic                     MemReady_i;
  logic                     MemReq_o;
  logic                     MemWE_o;
  logic                     AdrSrc_o;
  logic                     IRWrite_o;
  logic                     PCWrite_o;
  logic                     ALUsrc_o;
  logic [CONTROL_WIDTH-1:0] ALUctrl_o;
  logic                     RegWrite_o;
  logic [1:0]               ResultSrc_o;
  logic                     Illegal_o;

  modport master (
    input  Instr_i, Zero_i, MemReady_i,
    output MemReq_o, MemWE_o, AdrSrc_o, IRWrite_o, PCWrite_o,
           ALUsrc_o, ALUctrl_o, RegWrite_o, ResultSrc_o, Illegal_o
  );

  modport slave (
    output Instr_i, Zero_i, MemReady_i,
    input  MemReq_o, MemWE_o, AdrSrc_o, IRWrite_o, PCWrite_o,
           ALUsrc_o, ALUctrl_o, RegWrite_o, ResultSrc_o, Illegal_o
  );
endinterface

// File: rtl/mc_ctrl_fsm_alu_decoder.sv
// Combinational funct3/funct7 -> ALU operation decode; flags unsupported funct3.
module alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       is_rtype_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_o
);

  // funct7[5] only selects SUB for register-register ops; on I-type it is an immediate bit
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    case (funct3_i)
      3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b111:  alu_ctrl_o = ALU_AND;
      3'b110:  alu_ctrl_o = ALU_OR;
      3'b010:  alu_ctrl_o = ALU_SLT;
      default: illegal_o  = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle RV32I main controller: one state per cycle, unified memory via req/ready.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int CONTROL_WIDTH = 3,
  parameter int DATA_WIDTH    = 32
) (
  input logic           clk,
  input logic           rst,
  mc_ctrl_fsm_if.master bus
);

  state_t     state_q, state_d;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] dec_ctrl;
  logic       dec_illegal;

  logic       mem_req, mem_we, adr_src, ir_write, pc_write;
  logic       alu_src, reg_write, illegal;
  logic [2:0] alu_ctrl;
  logic [1:0] result_src;

  assign opcode = bus.Instr_i[6:0];
  assign funct3 = bus.Instr_i[14:12];

  // Instruction bits the controller never looks at (register indices, immediates)
  logic unused_instr_bits;
  assign unused_instr_bits = ^{bus.Instr_i[DATA_WIDTH-1:31], bus.Instr_i[29:15], bus.Instr_i[11:7]};

  alu_decoder u_alu_dec (
    .funct3_i   (funct3),
    .funct7b5_i (bus.Instr_i[30]),
    .is_rtype_i (opcode == OP_RTYPE),
    .alu_ctrl_o (dec_ctrl),
    .illegal_o  (dec_illegal)
  );

  // State register; reset forces FETCH asynchronously, discarding any in-flight access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state and per-state output decode
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src    = 1'b0;
    alu_ctrl   = ALU_ADD;
    reg_write  = 1'b0;
    result_src = RES_ALU;
    illegal    = 1'b0;
    case (state_q)
      FETCH: begin
        // While rst is held the state already sits in FETCH; masking here keeps the
        // request and any IR/PC update off until reset is released.
        if (!rst) begin
          mem_req = 1'b1;
          if (bus.MemReady_i) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end
        end
      end
      DECODE: begin
        case (opcode)
          OP_RTYPE:          state_d = EXECR;
          OP_ITYPE:          state_d = EXECI;
          OP_LOAD, OP_STORE: state_d = MEMADR;
          OP_BRANCH:         state_d = BRANCH;
          OP_JAL:            state_d = JAL;
          default:           state_d = TRAP;
        endcase
      end
      EXECR: begin
        alu_ctrl = dec_ctrl;
        state_d  = dec_illegal ? TRAP : ALUWB;
      end
      EXECI: begin
        alu_src  = 1'b1;
        alu_ctrl = dec_ctrl;
        state_d  = dec_illegal ? TRAP : ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      MEMADR: begin
        alu_src = 1'b1;
        state_d = (opcode == OP_LOAD) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (bus.MemReady_i) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        result_src = RES_MEM;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (bus.MemReady_i) state_d = FETCH;
      end
      BRANCH: begin
        alu_ctrl = ALU_SUB;
        // beq/bne only: funct3[0] inverts the sense of the zero flag
        if (funct3[2:1] == 2'b00) begin
          pc_write = bus.Zero_i ^ funct3[0];
          state_d  = FETCH;
        end else begin
          state_d = TRAP;
        end
      end
      JAL: begin
        reg_write  = 1'b1;
        result_src = RES_PC4;
        pc_write   = 1'b1;
        state_d    = FETCH;
      end
      TRAP: begin
        // Only reset leaves TRAP, which makes the flag sticky
        illegal = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.MemReq_o    = mem_req;
  assign bus.MemWE_o     = mem_we;
  assign bus.AdrSrc_o    = adr_src;
  assign bus.IRWrite_o   = ir_write;
  assign bus.PCWrite_o   = pc_write;
  assign bus.ALUsrc_o    = alu_src;
  assign bus.ALUctrl_o   = CONTROL_WIDTH'(alu_ctrl);
  assign bus.RegWrite_o  = reg_write;
  assign bus.ResultSrc_o = result_src;
  assign bus.Illegal_o   = illegal;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-scenario tasks with hand-computed output vectors.
module tb_mc_ctrl_fsm;
  import mc_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   vectors = 0;
  int   errors  = 0;
  bit   chk_en  = 1'b0;

  mc_ctrl_fsm_if #(.CONTROL_WIDTH(3), .DATA_WIDTH(32)) u_if ();

  mc_ctrl_fsm #(.CONTROL_WIDTH(3), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  // {MemReq, MemWE, AdrSrc, IRWrite, PCWrite, ALUsrc, ALUctrl[2:0], RegWrite, ResultSrc[1:0], Illegal}
  logic [12:0] obs;
  assign obs = {u_if.MemReq_o, u_if.MemWE_o, u_if.AdrSrc_o, u_if.IRWrite_o, u_if.PCWrite_o,
                u_if.ALUsrc_o, u_if.ALUctrl_o, u_if.RegWrite_o, u_if.ResultSrc_o, u_if.Illegal_o};

  localparam logic [12:0] O_IDLE      = 13'b0_0_0_0_0_0_000_0_00_0;
  localparam logic [12:0] O_FETCH     = 13'b1_0_0_0_0_0_000_0_00_0;
  localparam logic [12:0] O_FETCH_RDY = 13'b1_0_0_1_1_0_000_0_00_0;
  localparam logic [12:0] O_ALUWB     = 13'b0_0_0_0_0_0_000_1_00_0;
  localparam logic [12:0] O_MEMADR    = 13'b0_0_0_0_0_1_000_0_00_0;
  localparam logic [12:0] O_MEMRD     = 13'b1_0_1_0_0_0_000_0_00_0;
  localparam logic [12:0] O_MEMWB     = 13'b0_0_0_0_0_0_000_1_01_0;
  localparam logic [12:0] O_MEMWR     = 13'b1_1_1_0_0_0_000_0_00_0;
  localparam logic [12:0] O_BR_NT     = 13'b0_0_0_0_0_0_001_0_00_0;
  localparam logic [12:0] O_BR_T      = 13'b0_0_0_0_1_0_001_0_00_0;
  localparam logic [12:0] O_JAL       = 13'b0_0_0_0_1_0_000_1_10_0;
  localparam logic [12:0] O_TRAP      = 13'b0_0_0_0_0_0_000_0_00_1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write enables are mutually exclusive in every cycle
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if ($countones({u_if.RegWrite_o, u_if.MemWE_o, u_if.IRWrite_o}) > 1) begin
        errors++;
        $display("FAIL onehot_we @%0t: RegWrite/MemWE/IRWrite=%b%b%b want at most one high", $time,
                 u_if.RegWrite_o, u_if.MemWE_o, u_if.IRWrite_o);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; u_if.Instr_i = '0; u_if.Zero_i = 1'b0; u_if.MemReady_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL reset_hold: got %b want %b", obs, O_IDLE); end
    rst = 1'b0;
    #1;
    vectors++;
    if (dut.state_q !== FETCH || obs !== O_FETCH) begin
      errors++; $display("FAIL reset_release: got %s %b want FETCH %b", dut.state_q.name(), obs, O_FETCH);
    end
    chk_en = 1'b1;
  endtask

  task automatic test_add();
    u_if.Instr_i = 32'h002081B3; u_if.MemReady_i = 1'b1;
    #1;
    vectors++;
    if (dut.state_q !== FETCH || obs !== O_FETCH_RDY) begin
      errors++; $display("FAIL add_c1: got %s %b want FETCH %b", dut.state_q.name(), obs, O_FETCH_RDY);
    end
    tick();
    vectors++;
    if (dut.state_q !== DECODE || obs !== O_IDLE) begin
      errors++; $display("FAIL add_c2: got %s %b want DECODE %b", dut.state_q.name(), obs, O_IDLE);
    end
    tick();
    vectors++;
    if (dut.state_q !== EXECR || obs !== O_IDLE) begin
      errors++; $display("FAIL add_c3: got %s %b want EXECR %b", dut.state_q.name(), obs, O_IDLE);
    end
    tick();
    vectors++;
    if (dut.state_q !== ALUWB || obs !== O_ALUWB) begin
      errors++; $display("FAIL add_c4: got %s %b want ALUWB %b", dut.state_q.name(), obs, O_ALUWB);
    end
    tick();
    vectors++;
    if (dut.state_q !== FETCH) begin errors++; $display("FAIL add_ret: got %s want FETCH", dut.state_q.name()); end
  endtask

  task automatic test_alu_ops();
    logic [31:0] ins  [6] = '{32'h402081B3, 32'h0020F1B3, 32'h0020E1B3,
                              32'hFFF00093, 32'h00502093, 32'h00707093};
    state_t      st   [6] = '{EXECR, EXECR, EXECR, EXECI, EXECI, EXECI};
    logic [12:0] want [6] = '{13'b0_0_0_0_0_0_001_0_00_0, 13'b0_0_0_0_0_0_010_0_00_0,
                              13'b0_0_0_0_0_0_011_0_00_0, 13'b0_0_0_0_0_1_000_0_00_0,
                              13'b0_0_0_0_0_1_101_0_00_0, 13'b0_0_0_0_0_1_010_0_00_0};
    u_if.MemReady_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      u_if.Instr_i = ins[i];
      tick(); tick();
      vectors++;
      if (dut.state_q !== st[i] || obs !== want[i]) begin
        errors++; $display("FAIL alu_exec[%0d]: got %s %b want %s %b", i, dut.state_q.name(), obs,
                           st[i].name(), want[i]);
      end
      tick();
      vectors++;
      if (dut.state_q !== ALUWB || obs !== O_ALUWB) begin
        errors++; $display("FAIL alu_wb[%0d]: got %s %b want ALUWB %b", i, dut.state_q.name(), obs, O_ALUWB);
      end
      tick();
    end
  endtask

  task automatic test_load_wait();
    u_if.Instr_i = 32'h0000A183; u_if.MemReady_i = 1'b1;
    tick();
    u_if.MemReady_i = 1'b0;
    tick();
    vectors++;
    if (dut.state_q !== MEMADR || obs !== O_MEMADR) begin
      errors++; $display("FAIL lw_adr: got %s %b want MEMADR %b", dut.state_q.name(), obs, O_MEMADR);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) u_if.MemReady_i = 1'b1;
      #1;
      vectors++;
      if (dut.state_q !== MEMRD || obs !== O_MEMRD) begin
        errors++; $display("FAIL lw_rd[%0d]: got %s %b want MEMRD %b", i, dut.state_q.name(), obs, O_MEMRD);
      end
      tick();
    end
    vectors++;
    if (dut.state_q !== MEMWB || obs !== O_MEMWB) begin
      errors++; $display("FAIL lw_wb: got %s %b want MEMWB %b", dut.state_q.name(), obs, O_MEMWB);
    end
    tick();
    vectors++;
    if (dut.state_q !== FETCH) begin errors++; $display("FAIL lw_ret: got %s want FETCH", dut.state_q.name()); end
  endtask

  task automatic test_latency();
    logic [31:0] ins [6] = '{32'h002081B3, 32'h0000A183, 32'h0020A023,
                             32'h00208063, 32'h00209063, 32'h000000EF};
    int          lat [6] = '{4, 5, 4, 3, 3, 3};
    int n;
    u_if.MemReady_i = 1'b1; u_if.Zero_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      u_if.Instr_i = ins[i];
      n = 0;
      do begin tick(); n++; end while (dut.state_q !== FETCH && n < 20);
      vectors++;
      if (n != lat[i]) begin errors++; $display("FAIL latency[%0d]: got %0d cycles want %0d", i, n, lat[i]); end
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins  [4] = '{32'h00209063, 32'h00209063, 32'h00208063, 32'h00208063};
    logic        zero [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [12:0] want [4] = '{O_BR_NT, O_BR_T, O_BR_T, O_BR_NT};
    u_if.MemReady_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.Instr_i = ins[i]; u_if.Zero_i = zero[i];
      tick(); tick();
      vectors++;
      if (dut.state_q !== BRANCH || obs !== want[i]) begin
        errors++; $display("FAIL branch[%0d]: got %s %b want BRANCH %b", i, dut.state_q.name(), obs, want[i]);
      end
      tick();
      vectors++;
      if (dut.state_q !== FETCH) begin errors++; $display("FAIL branch_ret[%0d]: got %s want FETCH", i, dut.state_q.name()); end
    end
    u_if.Zero_i = 1'b0;
  endtask

  task automatic test_jal();
    u_if.Instr_i = 32'h000000EF; u_if.MemReady_i = 1'b1;
    tick(); tick();
    vectors++;
    if (dut.state_q !== JAL || obs !== O_JAL) begin
      errors++; $display("FAIL jal: got %s %b want JAL %b", dut.state_q.name(), obs, O_JAL);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    u_if.Instr_i = 32'h0020A023; u_if.MemReady_i = 1'b1;
    tick();
    u_if.MemReady_i = 1'b0;
    tick(); tick(); tick();
    vectors++;
    if (dut.state_q !== MEMWR || obs !== O_MEMWR) begin
      errors++; $display("FAIL sw_wait: got %s %b want MEMWR %b", dut.state_q.name(), obs, O_MEMWR);
    end
    #2;
    rst = 1'b1; u_if.MemReady_i = 1'b1;
    #1;
    vectors++;
    if (dut.state_q !== FETCH || obs !== O_IDLE) begin
      errors++; $display("FAIL rst_mid_wr: got %s %b want FETCH %b", dut.state_q.name(), obs, O_IDLE);
    end
    tick();
    vectors++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL rst_held: got %b want %b", obs, O_IDLE); end
    u_if.MemReady_i = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (dut.state_q !== FETCH || obs !== O_FETCH) begin
      errors++; $display("FAIL rst_restart: got %s %b want FETCH %b", dut.state_q.name(), obs, O_FETCH);
    end
  endtask

  task automatic test_bad_funct();
    u_if.Instr_i = 32'h002091B3; u_if.MemReady_i = 1'b1;
    tick(); tick();
    vectors++;
    if (dut.state_q !== EXECR || obs !== O_IDLE) begin
      errors++; $display("FAIL sll_exec: got %s %b want EXECR %b", dut.state_q.name(), obs, O_IDLE);
    end
    tick();
    vectors++;
    if (dut.state_q !== TRAP || obs !== O_TRAP) begin
      errors++; $display("FAIL sll_trap: got %s %b want TRAP %b", dut.state_q.name(), obs, O_TRAP);
    end
    rst = 1'b1; tick(); u_if.MemReady_i = 1'b0; rst = 1'b0; #1;
    u_if.Instr_i = 32'h0020C063; u_if.Zero_i = 1'b1; u_if.MemReady_i = 1'b1;
    tick(); tick();
    vectors++;
    if (dut.state_q !== BRANCH || obs !== O_BR_NT) begin
      errors++; $display("FAIL blt_branch: got %s %b want BRANCH %b", dut.state_q.name(), obs, O_BR_NT);
    end
    tick();
    vectors++;
    if (dut.state_q !== TRAP || obs !== O_TRAP) begin
      errors++; $display("FAIL blt_trap: got %s %b want TRAP %b", dut.state_q.name(), obs, O_TRAP);
    end
    rst = 1'b1; tick(); u_if.MemReady_i = 1'b0; u_if.Zero_i = 1'b0; rst = 1'b0; #1;
  endtask

  task automatic test_trap();
    u_if.Instr_i = 32'h0000007F; u_if.MemReady_i = 1'b1;
    tick(); tick();
    vectors++;
    if (dut.state_q !== TRAP || obs !== O_TRAP) begin
      errors++; $display("FAIL trap_entry: got %s %b want TRAP %b", dut.state_q.name(), obs, O_TRAP);
    end
    for (int i = 0; i < 10; i++) begin
      u_if.MemReady_i = i[0];
      tick();
      vectors++;
      if (dut.state_q !== TRAP || obs !== O_TRAP) begin
        errors++; $display("FAIL trap_hold[%0d]: got %s %b want TRAP %b", i, dut.state_q.name(), obs, O_TRAP);
      end
    end
    u_if.MemReady_i = 1'b0;
    rst = 1'b1;
    #1;
    vectors++;
    if (obs !== O_IDLE) begin errors++; $display("FAIL trap_clear: got %b want %b", obs, O_IDLE); end
    tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (dut.state_q !== FETCH || obs !== O_FETCH) begin
      errors++; $display("FAIL trap_restart: got %s %b want FETCH %b", dut.state_q.name(), obs, O_FETCH);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_alu_ops();
    test_load_wait();
    test_latency();
    test_branch();
    test_jal();
    test_reset_mid_write();
    test_bad_funct();
    test_trap();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
